instr_fetch_unit: RTL

Instruction fetch and program-buffer stage sitting directly upstream of the 4-bit accumulator CPU core. It holds a small program (one 8-bit instruction word per entry: opcode in bits [7:4], immediate in bits [3:0]) that is loaded byte-by-byte. On command it streams the words to the core over a valid/ready handshake. The core can redirect the stream with a jump, and the unit stops on a HALT opcode or at the end of the loaded program.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / program buffer feeding the accumulator core over valid/ready.
// Words are loaded while stopped, then streamed from address 0 on start until HALT or end of program.
module instr_fetch_unit #(
    parameter int         DEPTH       = 16,
    parameter int         AW          = 4,
    parameter int         IW          = 8,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic [AW:0]   prog_len,
    output logic          running,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          mem_we;
    logic          fetch;
    logic          xfer;
    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            pc_q       <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
        end
    end

    // Program storage is deliberately not reset; only addresses below prog_len are ever read out.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= load_data;
        end
    end

    assign xfer = (state_q == RUN) && instr_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        pc_d       = pc_q;
        mem_we     = 1'b0;
        fetch      = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (load_en) begin
                    mem_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    prog_len_d = (prog_len_q == FULL_LEN) ? FULL_LEN : prog_len_q + 1'b1;
                end else if (start && (prog_len_q != '0)) begin
                    state_d = RUN;
                    pc_d    = '0;
                    fetch   = 1'b1;
                end
            end
            RUN: begin
                if (xfer && (instr_q[IW-1 -: 4] == HALT_OPCODE)) begin
                    state_d = HALT;
                end else if (jump_en && ({1'b0, jump_addr} < prog_len_q)) begin
                    pc_d  = jump_addr;
                    fetch = 1'b1;
                end else if (jump_en) begin
                    state_d = HALT;
                    pc_d    = jump_addr;
                end else if (xfer && ({1'b0, pc_q} == prog_len_q - 1'b1)) begin
                    state_d = HALT;
                    pc_d    = prog_len_q[AW-1:0];
                end else if (xfer) begin
                    pc_d  = pc_q + 1'b1;
                    fetch = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The presented word is registered; it only changes when a new address is fetched.
    always_comb begin
        instr_d = instr_q;
        if (fetch) begin
            instr_d = mem_q[pc_d];
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = (state_q == RUN);
    assign pc          = pc_q;
    assign prog_len    = prog_len_q;
    assign running     = (state_q == RUN);
    assign halted      = (state_q == HALT);

endmodule
